// File: rtl/macro_keys_pkg.sv
// rtl/macro_keys_pkg.sv - shared FSM state type and HID keycodes for the macro-pad path
package macro_keys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } mk_state_e;

    // HID usage IDs for the letters a..d, shared with the keystroke sender
    localparam logic [7:0] HID_A = 8'h04;
    localparam logic [7:0] HID_B = 8'h05;
    localparam logic [7:0] HID_C = 8'h06;
    localparam logic [7:0] HID_D = 8'h07;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus stable-level debouncer for one button
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed_level,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]    sync_q, sync_d;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          pressed_now;

    assign pressed_now = ~sync_q[1];

    // Count consecutive cycles where the synced level disagrees with the accepted state
    always_comb begin
        sync_d  = {sync_q[0], key_n};
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (pressed_now == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            state_d = pressed_now;
            cnt_d   = '0;
            pulse_d = pressed_now;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser resets to the released (high) level so reset never fakes a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pressed_level = state_q;
    assign press_pulse   = pulse_q;

endmodule

// File: rtl/macro_key_event_queue.sv
// rtl/macro_key_event_queue.sv - debounced key presses queued as HID codes for the keystroke sender
module macro_key_event_queue
    import macro_keys_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int SYS_FREQ        = 12_090_000,
    parameter int DEBOUNCE_CYCLES = SYS_FREQ / 50,
    parameter logic [NUM_KEYS*8-1:0] KEYMAP = {HID_D, HID_C, HID_B, HID_A},
    parameter int FIFO_DEPTH      = 4,
    parameter int WAIT_TIMEOUT    = SYS_FREQ
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic                sender_done,
    output logic                start,
    output logic [7:0]          keycode,
    output logic                busy,
    output logic                overflow,
    output logic                timeout_err
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int TW   = $clog2(WAIT_TIMEOUT) + 1;

    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_pulse;
    logic [NUM_KEYS-1:0] press_vec;

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk          (clk),
                .rst_n        (rst_n),
                .key_n        (keys_n[g]),
                .pressed_level(key_level[g]),
                .press_pulse  (key_pulse[g])
            );
        end
    endgenerate

    // The pulse fires on the same edge the level becomes pressed; gating is a cheap sanity guard
    assign press_vec = key_pulse & key_level;

    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic [NUM_KEYS-1:0] grant;
    logic [7:0]          push_data;
    logic                push, pop;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            fifo_full, fifo_empty;

    mk_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          start_q, start_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic          timer_expired;

    assign fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Fixed-priority pick of the lowest pending key and its mapped HID code
    always_comb begin
        grant     = '0;
        push_data = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pending_q[i] && (grant == '0)) begin
                grant[i]  = 1'b1;
                push_data = KEYMAP[i*8 +: 8];
            end
        end
    end

    assign push = (|pending_q) && !fifo_full;

    // Pending bits hold presses the full FIFO cannot take; a repeat press of a waiting key is lost
    always_comb begin
        pending_d  = (pending_q & ~(push ? grant : '0)) | press_vec;
        overflow_d = overflow_q | (|(press_vec & pending_q & ~(push ? grant : '0)));
    end

    // Circular keycode buffer; pointers wrap naturally because the depth is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    assign timer_expired = (state_q == ST_WAIT) && (timer_q == TW'(WAIT_TIMEOUT - 1));

    // Handshake next state: launch on a queued code, wait for done or timeout, then one settle cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_WAIT;
            ST_WAIT: if (sender_done || timer_expired) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; done wins over a timeout landing on the same cycle
    always_comb begin
        pop       = 1'b0;
        start_d   = 1'b0;
        keycode_d = keycode_q;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
        timer_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    start_d   = 1'b1;
                    keycode_d = mem_q[rd_ptr_q];
                    busy_d    = 1'b1;
                end
            end
            ST_WAIT: begin
                timer_d   = timer_q + TW'(1);
                busy_d    = !(sender_done || timer_expired);
                timeout_d = timer_expired && !sender_done;
            end
            default: begin
            end
        endcase
    end

    // State register for queue, arbiter and handshake; reset also aborts an in-flight send
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            start_q    <= 1'b0;
            keycode_q  <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            start_q    <= start_d;
            keycode_q  <= keycode_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign start       = start_q;
    assign keycode     = keycode_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule
